// File: rtl/cycle_sequencer_if.sv
// Handshake bundle between the cycle sequencer and the microcode blocks.
// The slave modport is the sequencer side; the master modport drives its inputs.
interface cycle_sequencer_if #(
    parameter int STEP_W  = 4,
    parameter int COUNT_W = 8
);
    logic               i_Stall;
    logic               i_IR_Fetch;
    logic               i_Halt;
    logic               i_Wake;
    logic [STEP_W-1:0]  o_Cycle_Step;
    logic [COUNT_W-1:0] o_Cycle_Count;
    logic               o_M_End;
    logic               o_Instr_Start;
    logic               o_Halted;
    logic               o_Overrun;

    modport master (
        output i_Stall, i_IR_Fetch, i_Halt, i_Wake,
        input  o_Cycle_Step, o_Cycle_Count, o_M_End,
               o_Instr_Start, o_Halted, o_Overrun
    );

    modport slave (
        input  i_Stall, i_IR_Fetch, i_Halt, i_Wake,
        output o_Cycle_Step, o_Cycle_Count, o_M_End,
               o_Instr_Start, o_Halted, o_Overrun
    );
endinterface

// File: rtl/cycle_sequencer.sv
// Cycle sequencer: one-hot T-state and M-cycle generator for the microcode
// blocks, with stall, HALT/wake handling and sticky M-cycle overrun flag.
module cycle_sequencer #(
    parameter int STEP_W  = 4,
    parameter int COUNT_W = 8
) (
    input  logic             i_Clk,
    input  logic             i_Reset_n,
    cycle_sequencer_if.slave bus
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    localparam logic [STEP_W-1:0]  STEP_T1  = STEP_W'(1);
    localparam logic [COUNT_W-1:0] COUNT_M1 = COUNT_W'(1);

    state_t             state_q, state_d;
    logic [STEP_W-1:0]  step_q, step_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               start_q, start_d;
    logic               overrun_q, overrun_d;
    logic               m_end;

    assign m_end = step_q[STEP_W-1] & ~bus.i_Stall;

    // State register: synchronous active-low reset wins over every other input.
    always_ff @(posedge i_Clk) begin
        if (!i_Reset_n) begin
            state_q   <= ST_RUN;
            step_q    <= STEP_T1;
            count_q   <= COUNT_M1;
            start_q   <= 1'b1;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            count_q   <= count_d;
            start_q   <= start_d;
            overrun_q <= overrun_d;
        end
    end

    // Next-state logic: step rotates every unstalled clock, count/state move only at M-end.
    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        count_d   = count_q;
        start_d   = start_q;
        overrun_d = overrun_q;

        if (!bus.i_Stall) begin
            step_d = {step_q[STEP_W-2:0], step_q[STEP_W-1]};

            // Leaving T1 ends the one-T-state instruction-start marker.
            if (step_q[0]) begin
                start_d = 1'b0;
            end

            if (m_end) begin
                unique case (state_q)
                    ST_RUN: begin
                        if (bus.i_Halt) begin
                            state_d = ST_HALT;
                            count_d = '0;
                        end else if (bus.i_IR_Fetch) begin
                            count_d = COUNT_M1;
                            start_d = 1'b1;
                        end else if (count_q[COUNT_W-1]) begin
                            count_d   = COUNT_M1;
                            overrun_d = 1'b1;
                            start_d   = 1'b1;
                        end else begin
                            count_d = {count_q[COUNT_W-2:0], 1'b0};
                        end
                    end
                    ST_HALT: begin
                        if (bus.i_Wake) begin
                            state_d = ST_RUN;
                            count_d = COUNT_M1;
                            start_d = 1'b1;
                        end
                    end
                    default: begin
                        state_d = ST_RUN;
                    end
                endcase
            end
        end
    end

    assign bus.o_Cycle_Step  = step_q;
    assign bus.o_Cycle_Count = count_q;
    assign bus.o_M_End       = m_end;
    assign bus.o_Instr_Start = start_q;
    assign bus.o_Halted      = (state_q == ST_HALT);
    assign bus.o_Overrun     = overrun_q;

endmodule

// File: tb/tb_cycle_sequencer.sv
// Self-checking bench for cycle_sequencer: an index-based reference model
// pushes expected post-edge values into a queue, which are popped and
// compared after each rising edge.
module tb_cycle_sequencer;

    localparam int STEP_W  = 4;
    localparam int COUNT_W = 8;

    typedef struct {
        string              tag;
        logic [STEP_W-1:0]  step;
        logic [COUNT_W-1:0] count;
        logic               start;
        logic               halted;
        logic               ovr;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    exp_t exp_q[$];

    // reference model state (indices, not shift registers)
    int s_idx    = 0;
    int c_idx    = 0;
    bit halt_m   = 0;
    bit start_m  = 0;
    bit ovr_m    = 0;
    bit model_ok = 0;

    always #5 clk = ~clk;

    cycle_sequencer_if #(.STEP_W(STEP_W), .COUNT_W(COUNT_W)) bus ();

    cycle_sequencer #(.STEP_W(STEP_W), .COUNT_W(COUNT_W)) dut (
        .i_Clk     (clk),
        .i_Reset_n (rst_n),
        .bus       (bus)
    );

    task automatic chk_bit(input string tag, input logic got, input logic want);
        checks++;
        assert (got === want) else begin
            failures++;
            $error("FAIL %s: got %b expected %b", tag, got, want);
        end
    endtask

    task automatic chk_vec(input string tag, input logic [7:0] got, input logic [7:0] want);
        checks++;
        assert (got === want) else begin
            failures++;
            $error("FAIL %s: got %b expected %b", tag, got, want);
        end
    endtask

    // One clock: drive inputs, check combinational M-end, update model, push, clock, pop, compare.
    task automatic cyc(input logic r, input logic st, input logic f, input logic h,
                       input logic w, input string tag);
        exp_t e;
        bit   mend;
        rst_n          = r;
        bus.i_Stall    = st;
        bus.i_IR_Fetch = f;
        bus.i_Halt     = h;
        bus.i_Wake     = w;
        #1;
        mend = (s_idx == STEP_W - 1) && !st;
        if (r && model_ok) begin
            chk_bit({tag, ".m_end"}, bus.o_M_End, mend);
        end

        if (!r) begin
            s_idx = 0; c_idx = 0; halt_m = 0; start_m = 1; ovr_m = 0;
            model_ok = 1;
        end else if (!st) begin
            if (s_idx == 0) start_m = 0;
            s_idx = (s_idx + 1) % STEP_W;
            if (mend) begin
                if (!halt_m) begin
                    if (h) begin
                        halt_m = 1;
                    end else if (f) begin
                        c_idx = 0; start_m = 1;
                    end else if (c_idx == COUNT_W - 1) begin
                        c_idx = 0; ovr_m = 1; start_m = 1;
                    end else begin
                        c_idx++;
                    end
                end else if (w) begin
                    halt_m = 0; c_idx = 0; start_m = 1;
                end
            end
        end

        e.tag    = tag;
        e.step   = STEP_W'(1) << s_idx;
        e.count  = halt_m ? '0 : (COUNT_W'(1) << c_idx);
        e.start  = start_m;
        e.halted = halt_m;
        e.ovr    = ovr_m;
        exp_q.push_back(e);

        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s.queue: got empty expected entry", tag);
        end else begin
            e = exp_q.pop_front();
            if (model_ok) begin
                chk_vec({e.tag, ".step"}, 8'(bus.o_Cycle_Step), 8'(e.step));
                chk_vec({e.tag, ".count"}, bus.o_Cycle_Count, e.count);
                chk_bit({e.tag, ".start"}, bus.o_Instr_Start, e.start);
                chk_bit({e.tag, ".halted"}, bus.o_Halted, e.halted);
                chk_bit({e.tag, ".overrun"}, bus.o_Overrun, e.ovr);
            end
        end
    endtask

    // Run plain cycles until the model reaches a given T-state (bounded by STEP_W clocks).
    task automatic run_to(input int target, input string tag);
        for (int k = 0; k < STEP_W && s_idx != target; k++) begin
            cyc(1, 0, 0, 0, 0, tag);
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.i_Stall    = 1'b0;
        bus.i_IR_Fetch = 1'b0;
        bus.i_Halt     = 1'b0;
        bus.i_Wake     = 1'b0;
        @(posedge clk);
        #1;

        // 1: reset held three clocks
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, "reset");
        chk_vec("reset.step_abs", 8'(bus.o_Cycle_Step), 8'h01);
        chk_vec("reset.count_abs", bus.o_Cycle_Count, 8'h01);

        // 2: two-M-cycle instruction, fetch flagged during M2
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 0, "instr2.m1");
        chk_vec("instr2.count_m2", bus.o_Cycle_Count, 8'h02);
        for (int i = 0; i < 4; i++) cyc(1, 0, 1, 0, 0, "instr2.m2");
        chk_vec("instr2.count_wrap", bus.o_Cycle_Count, 8'h01);
        chk_bit("instr2.start_abs", bus.o_Instr_Start, 1'b1);

        // 3: stall at step=0100, count=02 with competing inputs asserted
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 0, "stall.pre");
        cyc(1, 0, 0, 0, 0, "stall.pre");
        cyc(1, 0, 0, 0, 0, "stall.pre");
        chk_vec("stall.step_at", 8'(bus.o_Cycle_Step), 8'h04);
        for (int i = 0; i < 5; i++) cyc(1, 1, 1, 1, 1, "stall.hold");
        cyc(1, 0, 0, 0, 0, "stall.resume");
        chk_vec("stall.step_after", 8'(bus.o_Cycle_Step), 8'h08);

        // 4: no fetch for more than 8 M-cycles -> overrun, sticky
        for (int i = 0; i < 40; i++) cyc(1, 0, 0, 0, 0, "overrun");
        chk_bit("overrun.sticky_abs", bus.o_Overrun, 1'b1);

        // 5: halt beats fetch; wake off T4 ignored; wake at T4 resumes
        run_to(STEP_W - 1, "halt.align");
        cyc(1, 0, 1, 1, 0, "halt.enter");
        chk_vec("halt.count_abs", bus.o_Cycle_Count, 8'h00);
        for (int i = 0; i < 6; i++) cyc(1, 0, 0, 0, 0, "halt.idle");
        run_to(1, "halt.align2");
        cyc(1, 0, 0, 0, 1, "halt.wake_early");
        run_to(STEP_W - 1, "halt.align3");
        cyc(1, 0, 0, 1, 1, "halt.wake");
        chk_bit("halt.woken_abs", bus.o_Halted, 1'b0);
        for (int i = 0; i < 6; i++) cyc(1, 0, 0, 0, 0, "halt.after");

        // 6: reset mid-operation while halted at step=0100
        run_to(STEP_W - 1, "midrst.align");
        cyc(1, 0, 0, 1, 0, "midrst.halt");
        run_to(2, "midrst.align2");
        cyc(0, 0, 1, 0, 1, "midrst.reset");
        chk_bit("midrst.overrun_abs", bus.o_Overrun, 1'b0);

        // random mix of stall/fetch/halt/wake with occasional reset
        for (int i = 0; i < 300; i++) begin
            cyc(($urandom_range(0, 63) != 0),
                ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 15) == 0),
                ($urandom_range(0, 3) == 0),
                "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
